// File: rtl/booth_pair_feeder_if.sv
// Operand/product handshake and Booth-multiplier side-band bundle for booth_pair_feeder.
// The slave modport is the feeder; master is whatever drives operands and hosts the multiplier.
interface booth_pair_feeder_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] multiplicand;
    logic [3:0] multiplier;
    logic       mult_rst;
    logic       mult_start;
    logic       mult_top;
    logic       mult_bottom;
    logic [3:0] mult_delta_m;
    logic [7:0] mult_result;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] product;
    logic       err;

    modport slave (
        input  in_valid, multiplicand, multiplier, mult_result, out_ready,
        output in_ready, mult_rst, mult_start, mult_top, mult_bottom, mult_delta_m,
               out_valid, product, err
    );

    modport master (
        output in_valid, multiplicand, multiplier, mult_result, out_ready,
        input  in_ready, mult_rst, mult_start, mult_top, mult_bottom, mult_delta_m,
               out_valid, product, err
    );
endinterface

// File: rtl/booth_pair_feeder.sv
// Serializes a 4-bit signed multiplier into radix-2 Booth pairs for an external multiplier and
// captures its 8-bit product. Optional result self-check: define BOOTH_FEEDER_CHECK_EN.
module booth_pair_feeder #(
    parameter int WAIT_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    booth_pair_feeder_if.slave   bus
);

    typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, WAIT, DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  mcd_q, mcd_d;
    logic [3:0]  mpr_q, mpr_d;
    logic [7:0]  product_q, product_d;
    logic        capture;
    logic [4:0]  pair_ext;
    logic [2:0]  bit_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            mcd_q     <= '0;
            mpr_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mcd_q     <= mcd_d;
            mpr_q     <= mpr_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcd_d     = mcd_q;
        mpr_d     = mpr_q;
        product_d = product_q;
        capture   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    mcd_d   = bus.multiplicand;
                    mpr_d   = bus.multiplier;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                if (cnt_q == 4'd3) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            WAIT: begin
                if (cnt_q == 4'(WAIT_CYCLES - 1)) begin
                    cnt_d     = '0;
                    capture   = 1'b1;
                    product_d = bus.mult_result;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Appending b[-1]=0 below the LSB makes pair i the slice {ext[i+1], ext[i]}.
    assign pair_ext = {mpr_q, 1'b0};
    assign bit_idx  = {1'b0, cnt_q[1:0]};

    always_comb begin
        bus.in_ready    = (state_q == IDLE);
        bus.mult_rst    = (state_q == IDLE) || (state_q == CLEAR) || (state_q == DONE);
        bus.mult_start  = (state_q == SHIFT) || (state_q == WAIT);
        bus.mult_top    = 1'b0;
        bus.mult_bottom = 1'b0;
        if (state_q == SHIFT) begin
            bus.mult_top    = pair_ext[bit_idx + 3'd1];
            bus.mult_bottom = pair_ext[bit_idx];
        end
        bus.mult_delta_m = mcd_q;
        bus.out_valid    = (state_q == DONE);
        bus.product      = product_q;
    end

`ifdef BOOTH_FEEDER_CHECK_EN
    logic              err_q, err_d;
    logic signed [7:0] mcd_ext, mpr_ext, ref_prod;

    assign mcd_ext  = {{4{mcd_q[3]}}, mcd_q};
    assign mpr_ext  = {{4{mpr_q[3]}}, mpr_q};
    assign ref_prod = mcd_ext * mpr_ext;

    always_comb begin
        err_d = err_q;
        if (capture && (bus.mult_result != ref_prod)) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

endmodule

// File: doc/booth_pair_feeder.md
BOOTH_PAIR_FEEDER -- requirements
Module: booth_pair_feeder

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 4: cycles held after the last Booth pair before the product is captured (legal range 1..15).
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  operand pair offered.
REQ-005 SHALL have port in_ready  output  1  block idle and accepting operands.
REQ-006 SHALL have port multiplicand  input  4  signed, forwarded as delta_m.
REQ-007 SHALL have port multiplier  input  4  signed, serialized as Booth pairs.
REQ-008 SHALL have port mult_rst  output  1  active-high clear to the downstream Booth multiplier.
REQ-009 SHALL have port mult_start  output  1  start to the downstream multiplier.
REQ-010 SHALL have port mult_top  output  1  current multiplier bit b[i].
REQ-011 SHALL have port mult_bottom  output  1  previous multiplier bit b[i-1], with b[-1]=0.
REQ-012 SHALL have port mult_delta_m  output  4  latched signed multiplicand.
REQ-013 SHALL have port mult_result  input  8  signed product returned by the multiplier.
REQ-014 SHALL have port out_valid  output  1  product available.
REQ-015 SHALL have port out_ready  input  1  consumer takes the product.
REQ-016 SHALL have port product  output  8  registered signed product.
REQ-017 SHALL have port err  output  1  sticky check-mismatch flag (see Configuration).

Function
REQ-018 SHALL implement FSM states IDLE, CLEAR, SHIFT, WAIT, DONE.
REQ-019 IDLE SHALL assert in_ready, mult_rst=1, mult_start=0; on in_valid&in_ready it latches both operands and goes to CLEAR.
REQ-020 CLEAR SHALL last exactly 1 cycle with mult_rst=1, mult_start=0, top=bottom=0, and mult_delta_m driving the latched multiplicand.
REQ-021 SHIFT SHALL last exactly 4 cycles, i=0..3 LSB first, driving mult_top=b[i] and mult_bottom=b[i-1], with mult_rst=0 and mult_start=1.
REQ-022 WAIT SHALL last WAIT_CYCLES cycles with top=bottom=0, mult_start=1, mult_rst=0.
REQ-023 On the edge leaving WAIT, the block SHALL register mult_result into product and enter DONE.
REQ-024 Latency: out_valid SHALL rise on the (WAIT_CYCLES+5)th rising edge after the accepting edge, i.e. edge 9 by default.
REQ-025 DONE SHALL hold out_valid=1, product stable, mult_rst=1, mult_start=0 until out_ready=1; it then returns to IDLE on that edge.
REQ-026 in_ready SHALL be 0 in every state except IDLE; in_valid offered outside IDLE is ignored and no operand is latched.
REQ-027 mult_delta_m SHALL remain constant from CLEAR through DONE and change only when new operands are accepted.
REQ-028 Zero multiplier SHALL still run all 4 SHIFT cycles with pairs (0,0).
REQ-029 Signed product range SHALL be -56..64; no saturation is applied.
REQ-030 Back-to-back operation: operands offered while in_valid is held across DONE->IDLE SHALL be accepted in the first IDLE cycle, giving one idle cycle between jobs.

Reset
REQ-031 Assertion of rst_n=0 SHALL, at any time including mid-SHIFT or mid-WAIT, force the following immediately: state=IDLE, in_ready=1, mult_rst=1, mult_start=0, mult_top=0, mult_bottom=0, mult_delta_m=0, product=0, out_valid=0, err=0.
REQ-032 A job interrupted by reset SHALL be discarded and SHALL never produce out_valid.

Configuration
REQ-033 Macro BOOTH_FEEDER_CHECK_EN defined: at capture, the block SHALL compare mult_result against the locally computed signed multiplicand*multiplier and set err=1 on mismatch; err stays 1 until reset.
REQ-034 Macro absent: err SHALL be tied to 0 and no check logic is synthesized.

Verification
REQ-035 Accept 7 and 3 -> SHIFT pairs (1,0),(1,1),(0,1),(0,0); delta_m=0111; product=21; out_valid on edge 9.
REQ-036 Accept -7 and -3 -> pairs (1,0),(0,1),(1,0),(1,1); product=21; accept -7 and 3 -> product=-21.
REQ-037 Accept -8 and -8 -> product=64; accept 0 and 5 -> pairs all (0,0) except none, product=0.
REQ-038 Hold out_ready=0 for 5 cycles in DONE -> out_valid and product stable, in_ready=0, a second in_valid is ignored; raising out_ready returns the block to IDLE.
REQ-039 Drop rst_n during the 2nd SHIFT cycle -> all outputs reach reset values without waiting for a clock edge; no out_valid follows; the next job runs normally.
REQ-040 With BOOTH_FEEDER_CHECK_EN, force mult_result=20 for 7*3 -> err=1 after capture and sticky; without the macro err=0.
